// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V fetch/decode constants and types
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] code;
      logic [XLEN-1:0] pc;
   } fetch_pkt_t;

endpackage

// File: rtl/prefetch_mem.sv
// rtl/prefetch_mem.sv - prefetch storage: one synchronous write port, one asynchronous read port
module prefetch_mem #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are deliberately unreset; the queue masks stale words while empty.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch queue between fetch and decode
module prefetch_queue
   import riscv_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_code,
   input  logic [ADDR_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_code,
   output logic [ADDR_W-1:0] out_pc,
   output logic [CW-1:0]     count,
   output logic              almost_full
);

   localparam int W = DATA_W + ADDR_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [W-1:0]  rdata;

   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign almost_full = (count >= AF_CNT);

   // A flush cancels any handshake in the same cycle.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   prefetch_mem #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({in_code, in_pc}),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Decode sees a NOP at PC 0 whenever nothing is queued.
   assign out_code = empty ? DATA_W'(NOP_INSTR) : rdata[W-1:ADDR_W];
   assign out_pc   = empty ? '0 : rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue
module tb_prefetch_queue;

   localparam int DEPTH = 4;
   localparam int AF    = DEPTH - 1;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_code = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_code;
   logic [31:0] out_pc;
   logic [2:0]  count;
   logic        almost_full;

   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

   logic [63:0] mq[$];

   always #5 clock = ~clock;

   prefetch_queue #(
      .DATA_W   (32),
      .ADDR_W   (32),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_code     (in_code),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_code    (out_code),
      .out_pc      (out_pc),
      .count       (count),
      .almost_full (almost_full)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference queue: ordered list of {code, pc}, updated by handshake rules.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
      end else begin
         automatic int  n      = mq.size();
         automatic bit  do_pop  = out_ready && (n > 0);
         automatic bit  do_push = in_valid && (n < DEPTH);
         if (flush) begin
            mq.delete();
         end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_code, in_pc});
         end
      end
   end

   always @(negedge clock) begin
      if (!done) begin
         automatic int n = mq.size();
         check("cmp_count", 64'(count), 64'(n));
         check("cmp_in_ready", 64'(in_ready), 64'(n < DEPTH));
         check("cmp_out_valid", 64'(out_valid), 64'(n > 0));
         check("cmp_almost_full", 64'(almost_full), 64'(n >= AF));
         check("cmp_out_code", 64'(out_code), (n > 0) ? 64'(mq[0][63:32]) : 64'(NOP));
         check("cmp_out_pc", 64'(out_pc), (n > 0) ? 64'(mq[0][31:0]) : 64'd0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_n(input int n, input logic [31:0] base_code, input logic [31:0] code_inc,
                         input logic [31:0] base_pc);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_code  = base_code + code_inc * i;
         in_pc    = base_pc + 32'(4 * i);
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_code", 64'(out_code), 64'h13);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_af", 64'(almost_full), 64'd0);

      // Fill to full, watching almost_full and in_ready.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_code  = 32'h11 * (i + 1);
         in_pc    = 32'(4 * i);
         step();
         check("fill_count", 64'(count), 64'(i + 1));
         check("fill_af", 64'(almost_full), 64'(i >= 2));
      end
      check("full_in_ready", 64'(in_ready), 64'd0);
      in_code = 32'h99;
      in_pc   = 32'h10;
      step();
      check("fifth_ignored_count", 64'(count), 64'd4);
      check("fifth_ignored_head", 64'(out_code), 64'h11);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_code", 64'(out_code), 64'(32'h11 * (i + 1)));
         check("drain_pc", 64'(out_pc), 64'(4 * i));
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", 64'(count), 64'd0);

      // Steady push+pop at count=2 across pointer wrap.
      push_n(2, 32'hA0, 32'h1, 32'h200);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_code  = 32'hB0 + 32'(i);
         in_pc    = 32'h300 + 32'(4 * i);
         check("stream_head", 64'(out_code), (i < 2) ? 64'(32'hA0 + i) : 64'(32'hB0 + i - 2));
         step();
         check("stream_count", 64'(count), 64'd2);
      end
      in_valid = 1'b0;
      repeat (2) step();
      out_ready = 1'b0;

      // Full with simultaneous push and pop: only the pop happens.
      push_n(4, 32'h11, 32'h11, 32'h0);
      in_valid  = 1'b1;
      in_code   = 32'h55;
      in_pc     = 32'h10;
      out_ready = 1'b1;
      step();
      check("fullpp_count", 64'(count), 64'd3);
      check("fullpp_head", 64'(out_code), 64'h22);
      out_ready = 1'b0;
      step();
      check("fullpp_accept", 64'(count), 64'd4);
      in_valid = 1'b0;

      // Asynchronous reset mid-stream at count=3.
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pre_rst_count", 64'(count), 64'd3);
      #2 reset = 1'b1;
      #1;
      check("async_rst_count", 64'(count), 64'd0);
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_code", 64'(out_code), 64'h13);
      check("async_rst_ready", 64'(in_ready), 64'd1);
      step();
      reset = 1'b0;

      // Flush together with a push discards both.
      push_n(3, 32'h11, 32'h11, 32'h0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_code  = 32'h55;
      in_pc    = 32'h40;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_code  = 32'h66;
      in_pc    = 32'h100;
      step();
      in_valid = 1'b0;
      check("post_flush_code", 64'(out_code), 64'h66);
      check("post_flush_pc", 64'(out_pc), 64'h100);
      out_ready = 1'b1;
      step();

      // Pops on an empty queue are ignored.
      for (int i = 0; i < 3; i++) begin
         step();
         check("empty_pop_count", 64'(count), 64'd0);
         check("empty_pop_code", 64'(out_code), 64'h13);
         check("empty_pop_pc", 64'(out_pc), 64'd0);
      end
      out_ready = 1'b0;

      @(negedge clock);
      #1 done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
